logic_op_arbiter: RTL



---
 rtl/logic_op_arb_pkg.sv | 44 ++++
 rtl/logic_op_arbiter_rr.sv | 69 ++++++
 rtl/logic_op_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/logic_op_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_arb_pkg
// Description : Shared types, widths and the bitwise operator function used
//               by the logic-op arbiter and its round-robin sub-block.
// Contents    : op_t    - 2-bit opcode enum (AND, OR, XOR, NOT)
//               OPW     - opcode width
//               CNTW    - grant counter width
//               MAX_DW  - widest operand the operator function supports
//               logic_op(op, a, b) - bitwise result, MAX_DW bits wide
// Revision    : 1.0 - initial release
// ============================================================================
package logic_op_arb_pkg;

    localparam int OPW    = 2;
    localparam int CNTW   = 16;
    localparam int MAX_DW = 64;

    typedef enum logic [OPW-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_t;

    // Operates at MAX_DW bits; callers truncate to their own width. Upper
    // bits of a NOT result are ones, but they are always discarded.
    function automatic logic [MAX_DW-1:0] logic_op(
        input op_t               op,
        input logic [MAX_DW-1:0] a,
        input logic [MAX_DW-1:0] b
    );
        logic [MAX_DW-1:0] res;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = ~a;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_op_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin priority search. The search starts at the pointer
//               and wraps modulo NREQ; the first asserted request wins. The
//               pointer moves to winner+1 only on an advance strobe.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset (pointer -> 0)
//               req        - request vector
//               advance    - winner was accepted this cycle
//               grant      - one-hot winner (zero when no request)
//               grant_idx  - binary index of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          w_found;
    int            w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            w_idx = (int'(ptr_q) + off) % NREQ;
            if (!w_found && req[w_idx[IW-1:0]]) begin
                w_found                 = 1'b1;
                grant[w_idx[IW-1:0]]    = 1'b1;
                grant_idx               = w_idx[IW-1:0];
            end
        end
    end

    // Explicit wrap so non-power-of-two NREQ also lands back on 0.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (grant_idx == IW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_arbiter
// Description : Shares one DW-bit bitwise logic unit between NREQ requesters.
//               One request is granted per cycle (round robin), the result is
//               registered and returned with the winner's ID over a
//               valid/ready response channel. A full, stalled result register
//               blocks all new grants.
// Ports       : clk, rst      - clock / synchronous active-high reset
//               req_valid/ready/op/a/b - per-requester request channel
//               rsp_valid/ready/data/id - response channel
//               grant_count   - accepted-request count
// Macro       : LOGIC_OP_ARB_STATS_EN - when defined, grant_count is a
//               saturating 16-bit counter; otherwise it is tied to zero and
//               no counter flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_arbiter
    import logic_op_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OPW*NREQ-1:0]      req_op,
    input  logic [DW*NREQ-1:0]       req_a,
    input  logic [DW*NREQ-1:0]       req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [CNTW-1:0]          grant_count
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic            w_can_accept;
    logic            w_xfer;
    op_t             w_op;
    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_b;
    logic [DW-1:0]   w_result;

    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q,  rsp_data_d;
    logic [IW-1:0]   rsp_id_q,    rsp_id_d;

    // Reset gating keeps req_ready low during rst even though the arbiter
    // itself is purely combinational.
    assign w_can_accept = (!rsp_valid_q || rsp_ready) && !rst;
    assign req_ready    = w_grant & {NREQ{w_can_accept}};
    assign w_xfer       = |req_ready;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_xfer),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_op     = op_t'(req_op[w_grant_idx*OPW +: OPW]);
    assign w_a      = req_a[w_grant_idx*DW +: DW];
    assign w_b      = req_b[w_grant_idx*DW +: DW];
    assign w_result = DW'(logic_op(w_op, MAX_DW'(w_a), MAX_DW'(w_b)));

    // EMPTY/FULL state is rsp_valid itself. A stalled FULL register cannot
    // see a transfer, so the else-branch only fires on a drain.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (w_xfer) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = w_result;
            rsp_id_d    = w_grant_idx;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef LOGIC_OP_ARB_STATS_EN
    logic [CNTW-1:0] grant_count_q, grant_count_d;

    always_comb begin
        grant_count_d = grant_count_q;
        if (w_xfer && (grant_count_q != {CNTW{1'b1}})) begin
            grant_count_d = grant_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`else
    assign grant_count = '0;
`endif

endmodule
`default_nettype wire
